l2_port_arbiter: RTL and testbench
==================================

// Module: l2_port_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single L1-side port of the L2 cache between N_REQ private L1 caches.
//  Serialises read/write requests, sequences the L2 busy handshake and returns read data to the winner.
//  On every completed write, issues a one-cycle invalidate broadcast to all other L1s (write-invalidate coherence).
//  Sits between the per-core L1 caches and the shared L2 cache.
// PARAMETERS
//  N_REQ   2   number of L1 requesters, 2..8
//  ADDR_W  15  word address width, matches the L2 word address
//  DATA_W  32  data word width
// PORTS
//  clk        in   1              system clock, rising edge
//  reset      in   1              asynchronous, active-high reset
//  req_read   in   N_REQ          per-L1 read request, level; held until that L1's done pulse
//  req_write  in   N_REQ          per-L1 write request, level; held until that L1's done pulse
//  req_addr   in   N_REQ*ADDR_W   per-L1 word address; slice i = [i*ADDR_W +: ADDR_W]
//  req_wdata  in   N_REQ*DATA_W   per-L1 write data; slice i = [i*DATA_W +: DATA_W]
//  done       out  N_REQ          one-hot, one-cycle completion pulse to the granted L1
//  rdata      out  DATA_W         read data; valid in the cycle done is high
//  l2_addr    out  ADDR_W         word address to the L2
//  l2_wdata   out  DATA_W         write data to the L2
//  l2_read    out  1              read request to the L2
//  l2_write   out  1              write request to the L2
//  l2_busy    in   1              L2 busy: high while the L2 is not idle
//  l2_rdata   in   DATA_W         L2 read data; registered by the L2 as it returns to idle
//  inv_valid  out  1              one-cycle invalidate strobe
//  inv_addr   out  ADDR_W         word address whose block the L1s must invalidate
//  inv_mask   out  N_REQ          L1s that must invalidate: all except the writer
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, grant=0. All outputs are 0: done, rdata, l2_*, inv_*.
//  Reset mid-transaction aborts. No done pulse is issued; the requester must re-request.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE:
//   - Active vector = req_read|req_write.
//   - If non-zero, the winner is the first active index at or after rr_ptr, wrapping from N_REQ-1 to 0.
//   - Register grant index; latch its addr, wdata and op. Write wins when read and write are both high.
//   - Go to ISSUE.
//  ISSUE:
//   - l2_read or l2_write asserted per latched op; l2_addr and l2_wdata driven from the latch.
//   - Stay until l2_busy=1, then go to WAIT. No timeout.
//  WAIT:
//   - l2_read/l2_write = latched op AND l2_busy. This is combinational.
//   - The request therefore drops in the same cycle the L2 returns to idle, so the L2 never restarts.
//   - On l2_busy=0: capture l2_rdata into rdata (reads only) and go to DONE.
//  DONE:
//   - done[grant]=1 for exactly one cycle.
//   - If the op was a write: inv_valid=1, inv_addr=latched addr, inv_mask=~(1<<grant) & all-ones(N_REQ).
//   - rr_ptr <= (grant+1) mod N_REQ. Go to IDLE.
//  Latency: unloaded transaction takes 2 arbiter cycles plus L2 busy cycles plus 1 cycle to done.
//  Minimum spacing between done pulses is 4 cycles.
//  Requests are sampled only in IDLE. Changes to req_addr or req_wdata after grant are ignored (latched).
//  A requester that drops its request before done still completes; done is still pulsed.
//  In non-ISSUE/WAIT states: l2_read=l2_write=0; l2_addr/l2_wdata hold their last value.
//  Invariants:
//   - done is one-hot or zero.
//   - inv_valid implies DONE state and a write.
//   - l2_read and l2_write are never both 1.
// TESTING
//  1. Reset; L1 0 reads 0x0123, L2 busy 6 cycles, returns 0xDEADBEEF
//     -> exactly one L2 read; done=01 once; rdata=0xDEADBEEF; inv_valid=0.
//  2. L1 0 and L1 1 both read in the same cycle, rr_ptr=0
//     -> L1 0 served first, then L1 1; never two granted concurrently; done order 01 then 10.
//  3. L1 1 writes 0x55AA55AA to 0x7FF0
//     -> l2_write=1 with l2_wdata=0x55AA55AA; with done=10, inv_valid=1, inv_addr=0x7FF0, inv_mask=01.
//  4. L1 0 holds requests back-to-back while L1 1 requests continuously
//     -> grants alternate 0,1,0,1; no starvation over 20 transactions.
//  5. L1 0 asserts read and write together -> the write is performed; one L2 transaction only.
//  6. Assert reset while in WAIT
//     -> all outputs 0 immediately; after release, a new request completes normally with rr_ptr=0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin share of the single L2 port among N_REQ L1s.
// Serialises L1 reads/writes and broadcasts write-invalidates to the other L1s.
module l2_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_read,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         done,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        l2_addr,
  output logic [DATA_W-1:0]        l2_wdata,
  output logic                     l2_read,
  output logic                     l2_write,
  input  logic                     l2_busy,
  input  logic [DATA_W-1:0]        l2_rdata,
  output logic                     inv_valid,
  output logic [ADDR_W-1:0]        inv_addr,
  output logic [N_REQ-1:0]         inv_mask
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     grant_inc;
  logic [IW-1:0]     win;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [N_REQ-1:0]  active;
  logic [N_REQ-1:0]  rot;
  logic [N_REQ-1:0]  grant_oh;
  int                off;
  int                pos;

  assign active = req_read | req_write;

  // Rotate so bit 0 is rr_ptr; lowest set bit is the winner offset.
  always_comb begin
    rot = N_REQ'({active, active} >> rr_ptr);
    off = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    pos = int'(rr_ptr) + off;
    if (pos >= N_REQ) pos = pos - N_REQ;
    win = IW'(pos);
  end

  always_comb begin
    grant_inc = grant + 1'b1;
    if (int'(grant) == N_REQ - 1) grant_inc = '0;
  end

  assign grant_oh = N_REQ'(1) << grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && |active) begin
        grant   <= win;
        op_wr   <= req_write[win];
        addr_q  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(win)*DATA_W +: DATA_W];
      end
      if (state == S_WAIT && !l2_busy && !op_wr) begin
        rdata_q <= l2_rdata;
      end
      if (state == S_DONE) begin
        rr_ptr <= grant_inc;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    l2_read   = 1'b0;
    l2_write  = 1'b0;
    done      = '0;
    inv_valid = 1'b0;
    inv_addr  = '0;
    inv_mask  = '0;
    unique case (state)
      S_IDLE: begin
        if (|active) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        l2_read  = !op_wr;
        l2_write = op_wr;
        if (l2_busy) state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Drop the request as the L2 goes idle so it never restarts.
        l2_read  = !op_wr && l2_busy;
        l2_write = op_wr && l2_busy;
        if (!l2_busy) state_nx = S_DONE;
      end
      S_DONE: begin
        done = grant_oh;
        if (op_wr) begin
          inv_valid = 1'b1;
          inv_addr  = addr_q;
          inv_mask  = ~grant_oh;
        end
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: random + directed bench for l2_port_arbiter.
// Holds an L2 memory model and a transaction-level arbiter model.
module tb_l2_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 15;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_read = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   l2_addr;
  logic [DW-1:0]   l2_wdata;
  logic            l2_read;
  logic            l2_write;
  logic            l2_busy = 1'b0;
  logic [DW-1:0]   l2_rdata = '0;
  logic            inv_valid;
  logic [AW-1:0]   inv_addr;
  logic [N-1:0]    inv_mask;

  always #5 clk = ~clk;

  l2_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_busy(l2_busy), .l2_rdata(l2_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .inv_mask(inv_mask)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Initial L2 contents for never-written words.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    if (a == 15'h0123) return 32'hDEADBEEF;
    return {17'h0, a} ^ 32'h3C5A_0000;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] act,
                                 input int rr);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (act[j]) return j;
    end
    return 0;
  endfunction

  // ---- model state (compare process only) ----
  bit            m_free = 1'b1;
  bit            m_pend, m_iss, m_saw, m_fin, m_op;
  int            m_who, m_rr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] shadow [int];
  int            cyc = 0;
  int            last_done_cyc = -100;

  // ---- events and samples published by the compare process ----
  int            done_cnt = 0;
  int            ev_who, ev_cyc;
  logic [N-1:0]  ev_done, ev_imask;
  logic [DW-1:0] ev_rdata;
  logic          ev_inv;
  logic [AW-1:0] ev_iaddr;
  logic [N-1:0]  done_s = '0;
  logic          s_rd = 1'b0, s_wr = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;

  logic [N-1:0]  e_done, e_mask, act;
  logic          e_req, e_inv, fin;
  logic [DW-1:0] e_rd;
  int            w;

  always @(negedge clk) begin
    cyc++;
    done_s  = done;
    s_rd    = l2_read;
    s_wr    = l2_write;
    s_addr  = l2_addr;
    s_wdata = l2_wdata;
    if (reset) begin
      chk("rst_ctl", {done, l2_read, l2_write, inv_valid, inv_mask}, '0);
      chk("rst_data", {rdata, l2_wdata}, '0);
      chk("rst_addr", {l2_addr, inv_addr}, '0);
      m_free = 1; m_pend = 0; m_iss = 0; m_saw = 0;
      m_fin = 0; m_rr = 0;
    end else begin
      fin    = m_pend && m_iss && m_saw && !l2_busy;
      e_req  = m_pend && m_iss && !fin;
      e_done = m_fin ? (N'(1) << m_who) : '0;
      e_inv  = m_fin && m_op;
      e_mask = e_inv ? ~(N'(1) << m_who) : '0;
      chk("done", done, e_done);
      chk("l2_read", l2_read, e_req && !m_op);
      chk("l2_write", l2_write, e_req && m_op);
      chk("inv_valid", inv_valid, e_inv);
      chk("inv_addr", inv_addr, e_inv ? m_addr : '0);
      chk("inv_mask", inv_mask, e_mask);
      if (e_req) begin
        chk("l2_addr", l2_addr, m_addr);
        chk("l2_wdata", l2_wdata, m_data);
      end
      if (m_fin && !m_op) begin
        e_rd = shadow.exists(int'(m_addr)) ?
               shadow[int'(m_addr)] : dflt(m_addr);
        chk("rdata", rdata, e_rd);
      end
      if (done != '0) begin
        chk("done_gap", cyc - last_done_cyc >= 4, 1);
        last_done_cyc = cyc;
      end
      if (m_fin) begin
        ev_who   = m_who;   ev_done  = done;
        ev_rdata = rdata;   ev_inv   = inv_valid;
        ev_iaddr = inv_addr; ev_imask = inv_mask;
        ev_cyc   = cyc;
        done_cnt++;
        if (m_op) shadow[int'(m_addr)] = m_data;
        m_rr = (m_who + 1) % N;
        m_fin = 0; m_pend = 0; m_free = 1;
      end else if (m_pend && m_iss) begin
        if (fin) begin
          m_iss = 0; m_fin = 1;
        end else if (l2_busy) begin
          m_saw = 1;
        end
      end else if (m_free) begin
        act = req_read | req_write;
        if (act != '0) begin
          w      = rr_pick(act, m_rr);
          m_who  = w;
          m_op   = req_write[w];
          m_addr = req_addr[w*AW +: AW];
          m_data = req_wdata[w*DW +: DW];
          m_pend = 1; m_iss = 1; m_saw = 0; m_free = 0;
        end
      end
    end
  end

  // ---- L2 model and requesters (main process only) ----
  logic [DW-1:0] l2mem [int];
  int            n_l2 = 0;
  int            b_cnt = 0;
  int            busy_len = 0;
  logic          lw_op = 1'b0;
  logic [AW-1:0] lw_addr = '0;
  logic [DW-1:0] lw_wdata = '0;
  bit            r_rd [N];
  bit            r_wr [N];
  logic [AW-1:0] r_a [N];
  logic [DW-1:0] r_d [N];
  bit            auto_on = 0, b2b = 0, drops = 0;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_read[i]           = r_rd[i];
      req_write[i]          = r_wr[i];
      req_addr[i*AW +: AW]  = r_a[i];
      req_wdata[i*DW +: DW] = r_d[i];
    end
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    r_rd[i] = rd; r_wr[i] = wr; r_a[i] = a; r_d[i] = d;
    pack();
  endtask

  task automatic new_req(input int i);
    int op;
    op = $urandom_range(0, 2);
    r_rd[i] = (op != 1);
    r_wr[i] = (op != 0);
    r_a[i]  = AW'($urandom_range(0, 15));
    r_d[i]  = $urandom;
  endtask

  task tick();
    @(posedge clk);
    #1;
    if (reset) begin
      l2_busy = 0; b_cnt = 0;
    end else if (!l2_busy) begin
      if (s_rd || s_wr) begin
        n_l2++;
        lw_op = s_wr; lw_addr = s_addr; lw_wdata = s_wdata;
        if (s_wr) l2mem[int'(s_addr)] = s_wdata;
        b_cnt = (busy_len != 0) ? busy_len - 1 :
                $urandom_range(0, 5);
        l2_busy = 1;
      end
    end else if (b_cnt == 0) begin
      l2_busy = 0;
      if (!lw_op)
        l2_rdata = l2mem.exists(int'(lw_addr)) ?
                   l2mem[int'(lw_addr)] : dflt(lw_addr);
    end else begin
      b_cnt--;
    end
    for (int i = 0; i < N; i++) begin
      if (done_s[i]) begin
        r_rd[i] = 0; r_wr[i] = 0;
        if (auto_on && b2b) new_req(i);
      end else if (auto_on) begin
        if (!(r_rd[i] || r_wr[i])) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (drops && $urandom_range(0, 31) == 0) begin
          r_rd[i] = 0; r_wr[i] = 0;
        end else if (drops && $urandom_range(0, 7) == 0) begin
          r_a[i] = AW'($urandom_range(0, 15));
          r_d[i] = $urandom;
        end
      end
    end
    pack();
  endtask

  task wait_done();
    int n0;
    n0 = done_cnt;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done_cnt != n0) break;
    end
    chk("done_timeout", done_cnt != n0, 1);
  endtask

  task drain();
    bit idle;
    idle = 0;
    auto_on = 0;
    for (int c = 0; c < 500 && !idle; c++) begin
      tick();
      idle = 1;
      for (int i = 0; i < N; i++)
        if (r_rd[i] || r_wr[i]) idle = 0;
    end
    chk("drain_timeout", idle, 1);
    repeat (20) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  int           t0, n0;
  logic [N-1:0] prev;
  bit           seen;

  initial begin
    for (int i = 0; i < N; i++) begin
      r_rd[i] = 0; r_wr[i] = 0; r_a[i] = '0; r_d[i] = '0;
    end
    repeat (3) tick();
    reset = 0;

    // single read, 6 busy cycles
    busy_len = 6;
    n0 = n_l2; t0 = cyc + 1;
    set_req(0, 1, 0, 15'h0123, '0);
    wait_done();
    chk("t1_done", ev_done, 2'b01);
    chk("t1_rdata", ev_rdata, 32'hDEADBEEF);
    chk("t1_inv", ev_inv, 0);
    chk("t1_l2n", n_l2 - n0, 1);
    chk("t1_lat", ev_cyc - t0, 9);
    busy_len = 0;

    // write by L1 1 with invalidate
    set_req(1, 0, 1, 15'h7FF0, 32'h55AA55AA);
    wait_done();
    chk("t3_who", ev_who, 1);
    chk("t3_done", ev_done, 2'b10);
    chk("t3_lwop", lw_op, 1);
    chk("t3_lwaddr", lw_addr, 15'h7FF0);
    chk("t3_lwdata", lw_wdata, 32'h55AA55AA);
    chk("t3_inv", ev_inv, 1);
    chk("t3_iaddr", ev_iaddr, 15'h7FF0);
    chk("t3_imask", ev_imask, 2'b01);

    // simultaneous reads, rr_ptr back at 0
    set_req(0, 1, 0, 15'h0010, '0);
    set_req(1, 1, 0, 15'h0011, '0);
    wait_done();
    chk("t2_who0", ev_who, 0);
    chk("t2_done0", ev_done, 2'b01);
    chk("t2_rd0", ev_rdata, 32'h3C5A0010);
    wait_done();
    chk("t2_done1", ev_done, 2'b10);
    chk("t2_rd1", ev_rdata, 32'h3C5A0011);

    // read+write together: write wins, one L2 op
    n0 = n_l2;
    set_req(0, 1, 1, 15'h0040, 32'h12345678);
    wait_done();
    chk("t5_l2n", n_l2 - n0, 1);
    chk("t5_lwop", lw_op, 1);
    chk("t5_done", ev_done, 2'b01);
    chk("t5_imask", ev_imask, 2'b10);
    set_req(0, 1, 0, 15'h0040, '0);
    wait_done();
    chk("t5_readback", ev_rdata, 32'h12345678);

    // reset in WAIT
    busy_len = 6;
    set_req(1, 1, 0, 15'h0123, '0);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      seen = l2_busy;
    end
    chk("t6_busy_seen", seen, 1);
    repeat (2) tick();
    reset = 1;
    #1;
    chk("t6_done", done, '0);
    chk("t6_l2rw", {l2_read, l2_write}, '0);
    chk("t6_inv", {inv_valid, inv_addr, inv_mask}, '0);
    chk("t6_data", {rdata, l2_wdata}, '0);
    chk("t6_addr", l2_addr, '0);
    for (int i = 0; i < N; i++) begin
      r_rd[i] = 0; r_wr[i] = 0;
    end
    pack();
    repeat (2) tick();
    reset = 0;
    busy_len = 0;
    set_req(0, 1, 0, 15'h0020, '0);
    set_req(1, 1, 0, 15'h0021, '0);
    wait_done();
    chk("t6_first", ev_done, 2'b01);
    chk("t6_rdata", ev_rdata, 32'h3C5A0020);
    wait_done();
    chk("t6_second", ev_done, 2'b10);

    // both requesters saturating: strict alternation
    drops = 0; b2b = 1; auto_on = 1;
    new_req(0); new_req(1); pack();
    prev = '0;
    for (int k = 0; k < 20; k++) begin
      wait_done();
      if (k > 0) chk("t4_alt", ev_done, prev ^ 2'b11);
      prev = ev_done;
    end
    drain();

    // random traffic
    drops = 1; auto_on = 1;
    for (int p = 0; p < 6; p++) begin
      b2b = $urandom_range(0, 1);
      repeat (500) tick();
    end
    drain();

    // one aborted transaction reached the L2 without a done
    chk("l2_txn_count", n_l2, done_cnt + 1);
    chk("l2_idle_end", l2_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
